// File: rtl/msi_snoop_ctrl.sv
// rtl/msi_snoop_ctrl.sv - MSI coherence state controller for one private cache
//
// Tracks a 2-bit MSI state per line, applies remote bus snoops every cycle and
// turns local CPU accesses into readMiss / invalidate / writeMiss bus requests.
// Signals write-backs but does not move data.
//
// Ports:
//   clock, resetn                 rising-edge clock, asynchronous active-low reset
//   cpu_valid/write/idx, ready    CPU access handshake (sampled when cpu_ready=1)
//   cpu_done                      one-cycle pulse, access complete
//   bus_req_valid/op/idx, ready   local bus request handshake
//   snoop_valid/op/idx            remote bus event, applied every cycle
//   wb_valid, wb_idx              one-cycle write-back pulse and its line
//   state_vec                     line i state at [2i+1:2i]

module msi_snoop_ctrl #(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   cpu_valid,
    input  logic                   cpu_write,
    input  logic [IDX_W-1:0]       cpu_idx,
    output logic                   cpu_ready,
    output logic                   cpu_done,
    output logic                   bus_req_valid,
    output logic [1:0]             bus_req_op,
    output logic [IDX_W-1:0]       bus_req_idx,
    input  logic                   bus_req_ready,
    input  logic                   snoop_valid,
    input  logic [1:0]             snoop_op,
    input  logic [IDX_W-1:0]       snoop_idx,
    output logic                   wb_valid,
    output logic [IDX_W-1:0]       wb_idx,
    output logic [2*NUM_LINES-1:0] state_vec
);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_E = 2'b01;
    localparam logic [1:0] ST_S = 2'b10;

    localparam logic [1:0] OP_RM  = 2'b00;
    localparam logic [1:0] OP_INV = 2'b01;
    localparam logic [1:0] OP_WM  = 2'b10;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'b00,
        FSM_REQ  = 2'b01,
        FSM_DONE = 2'b10
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [1:0] line_q   [NUM_LINES];
    logic [1:0] line_snp [NUM_LINES];
    logic [1:0] line_d   [NUM_LINES];
    logic       req_write;
    logic       wb_d;
    logic [1:0] cpu_line;
    logic       accept_miss;
    logic [1:0] miss_op;
    logic       grant;
    logic       pend_killed;

    // The unused encoding 2'b11 reads as invalid.
    function automatic logic [1:0] norm(input logic [1:0] s);
        return (s == 2'b11) ? ST_I : s;
    endfunction

    // Snoop effect on every line, plus the post-snoop state of the CPU line.
    always_comb begin
        logic [1:0] cur;
        cur      = ST_I;
        wb_d     = 1'b0;
        cpu_line = ST_I;
        for (int i = 0; i < NUM_LINES; i++) begin
            cur         = norm(line_q[i]);
            line_snp[i] = cur;
            if (snoop_valid && snoop_idx == IDX_W'(i)) begin
                case (cur)
                    ST_E: begin
                        case (snoop_op)
                            OP_RM:  begin line_snp[i] = ST_S; wb_d = 1'b1; end
                            OP_WM:  begin line_snp[i] = ST_I; wb_d = 1'b1; end
                            OP_INV: line_snp[i] = ST_I;
                            default: ;
                        endcase
                    end
                    ST_S: begin
                        if (snoop_op == OP_WM || snoop_op == OP_INV)
                            line_snp[i] = ST_I;
                    end
                    default: ;
                endcase
            end
            // Decide hit/miss on the state the line will hold after this
            // edge, so a same-cycle snoop cannot leave a stale hit behind.
            if (cpu_idx == IDX_W'(i))
                cpu_line = line_snp[i];
        end
    end

    // A pending line is never exclusive, so only a shared->invalid snoop
    // matters; an invalidate request must then be upgraded to writeMiss.
    assign pend_killed = (fsm_q == FSM_REQ) && snoop_valid && (snoop_idx == bus_req_idx)
                         && (snoop_op == OP_WM || snoop_op == OP_INV);

    always_comb begin
        fsm_d         = fsm_q;
        cpu_ready     = 1'b0;
        cpu_done      = 1'b0;
        bus_req_valid = 1'b0;
        accept_miss   = 1'b0;
        miss_op       = OP_RM;
        grant         = 1'b0;
        case (fsm_q)
            FSM_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_valid) begin
                    if ((!cpu_write && cpu_line != ST_I) || (cpu_write && cpu_line == ST_E)) begin
                        fsm_d = FSM_DONE;
                    end else begin
                        fsm_d       = FSM_REQ;
                        accept_miss = 1'b1;
                        if (!cpu_write)
                            miss_op = OP_RM;
                        else if (cpu_line == ST_S)
                            miss_op = OP_INV;
                        else
                            miss_op = OP_WM;
                    end
                end
            end
            FSM_REQ: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) begin
                    grant = 1'b1;
                    fsm_d = FSM_DONE;
                end
            end
            FSM_DONE: begin
                cpu_done = 1'b1;
                fsm_d    = FSM_IDLE;
            end
            default: fsm_d = FSM_IDLE;
        endcase
    end

    // Grant target state overrides any same-edge snoop on the pending line.
    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            line_d[i] = line_snp[i];
            if (grant && bus_req_idx == IDX_W'(i))
                line_d[i] = req_write ? ST_E : ST_S;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fsm_q       <= FSM_IDLE;
            req_write   <= 1'b0;
            bus_req_op  <= OP_RM;
            bus_req_idx <= '0;
            wb_valid    <= 1'b0;
            wb_idx      <= '0;
            for (int i = 0; i < NUM_LINES; i++)
                line_q[i] <= ST_I;
        end else begin
            fsm_q    <= fsm_d;
            wb_valid <= wb_d;
            if (wb_d)
                wb_idx <= snoop_idx;
            for (int i = 0; i < NUM_LINES; i++)
                line_q[i] <= line_d[i];
            if (accept_miss) begin
                req_write   <= cpu_write;
                bus_req_idx <= cpu_idx;
                bus_req_op  <= miss_op;
            end else if (!grant && pend_killed && bus_req_op == OP_INV) begin
                bus_req_op <= OP_WM;
            end
        end
    end

    always_comb begin
        state_vec = '0;
        for (int i = 0; i < NUM_LINES; i++)
            state_vec[2*i +: 2] = line_q[i];
    end

endmodule

// File: tb/tb_msi_snoop_ctrl.sv
// tb/tb_msi_snoop_ctrl.sv - directed self-checking bench for msi_snoop_ctrl

module tb_msi_snoop_ctrl;

    localparam int NUM_LINES = 4;
    localparam int IDX_W     = 2;

    logic                   clock;
    logic                   resetn;
    logic                   cpu_valid;
    logic                   cpu_write;
    logic [IDX_W-1:0]       cpu_idx;
    logic                   cpu_ready;
    logic                   cpu_done;
    logic                   bus_req_valid;
    logic [1:0]             bus_req_op;
    logic [IDX_W-1:0]       bus_req_idx;
    logic                   bus_req_ready;
    logic                   snoop_valid;
    logic [1:0]             snoop_op;
    logic [IDX_W-1:0]       snoop_idx;
    logic                   wb_valid;
    logic [IDX_W-1:0]       wb_idx;
    logic [2*NUM_LINES-1:0] state_vec;

    int checks = 0;
    int errors = 0;

    msi_snoop_ctrl #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .cpu_valid     (cpu_valid),
        .cpu_write     (cpu_write),
        .cpu_idx       (cpu_idx),
        .cpu_ready     (cpu_ready),
        .cpu_done      (cpu_done),
        .bus_req_valid (bus_req_valid),
        .bus_req_op    (bus_req_op),
        .bus_req_idx   (bus_req_idx),
        .bus_req_ready (bus_req_ready),
        .snoop_valid   (snoop_valid),
        .snoop_op      (snoop_op),
        .snoop_idx     (snoop_idx),
        .wb_valid      (wb_valid),
        .wb_idx        (wb_idx),
        .state_vec     (state_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Miss access completed with an immediate grant: accept, REQ, DONE, IDLE.
    task automatic quick_miss(input logic wr, input logic [IDX_W-1:0] idx);
        cpu_valid = 1'b1; cpu_write = wr; cpu_idx = idx; bus_req_ready = 1'b1;
        tick();
        cpu_valid = 1'b0;
        tick();
        bus_req_ready = 1'b0;
        tick();
    endtask

    initial begin
        resetn = 1'b0; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_idx = '0;
        bus_req_ready = 1'b0; snoop_valid = 1'b0; snoop_op = 2'b00; snoop_idx = '0;
        tick(); tick();
        check("rst_cpu_ready", cpu_ready, 1);
        check("rst_cpu_done", cpu_done, 0);
        check("rst_req_valid", bus_req_valid, 0);
        check("rst_req_op", bus_req_op, 0);
        check("rst_req_idx", bus_req_idx, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_idx", wb_idx, 0);
        check("rst_state_vec", state_vec, 0);
        resetn = 1'b1;
        tick();

        // Write miss on invalid line 2, bus ready immediately.
        cpu_valid = 1'b1; cpu_write = 1'b1; cpu_idx = 2'd2; bus_req_ready = 1'b1;
        tick();
        cpu_valid = 1'b0;
        check("t1_req_valid", bus_req_valid, 1);
        check("t1_req_op", bus_req_op, 2'b10);
        check("t1_req_idx", bus_req_idx, 2);
        check("t1_ready_busy", cpu_ready, 0);
        tick();
        bus_req_ready = 1'b0;
        check("t1_done", cpu_done, 1);
        check("t1_line2", state_vec[5:4], 2'b01);
        tick();
        check("t1_done_pulse", cpu_done, 0);
        check("t1_ready_back", cpu_ready, 1);

        // Snoop readMiss on exclusive line 2, then writeMiss on shared line 2.
        snoop_valid = 1'b1; snoop_op = 2'b00; snoop_idx = 2'd2;
        tick();
        snoop_valid = 1'b0;
        check("t2_wb_valid", wb_valid, 1);
        check("t2_wb_idx", wb_idx, 2);
        check("t2_line2_s", state_vec[5:4], 2'b10);
        snoop_valid = 1'b1; snoop_op = 2'b10; snoop_idx = 2'd2;
        tick();
        snoop_valid = 1'b0;
        check("t2_line2_i", state_vec[5:4], 2'b00);
        check("t2_no_wb", wb_valid, 0);

        // Read miss makes line 1 shared.
        cpu_valid = 1'b1; cpu_write = 1'b0; cpu_idx = 2'd1; bus_req_ready = 1'b1;
        tick();
        cpu_valid = 1'b0;
        check("t3_rd_op", bus_req_op, 2'b00);
        check("t3_rd_idx", bus_req_idx, 1);
        tick();
        bus_req_ready = 1'b0;
        check("t3_line1_s", state_vec[3:2], 2'b10);
        tick();

        // Write to shared line 1 with the bus stalled for three cycles.
        cpu_valid = 1'b1; cpu_write = 1'b1; cpu_idx = 2'd1;
        tick();
        cpu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_hold_valid%0d", k), bus_req_valid, 1);
            check($sformatf("t3_hold_op%0d", k), bus_req_op, 2'b01);
            check($sformatf("t3_hold_idx%0d", k), bus_req_idx, 1);
            tick();
        end
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        check("t3_line1_e", state_vec[3:2], 2'b01);
        check("t3_done", cpu_done, 1);
        tick();
        check("t3_done_pulse", cpu_done, 0);

        // Invalidate the pending line while op=invalidate.
        snoop_valid = 1'b1; snoop_op = 2'b00; snoop_idx = 2'd1;
        tick();
        snoop_valid = 1'b0;
        check("t4_wb_idx", wb_idx, 1);
        check("t4_line1_s", state_vec[3:2], 2'b10);
        cpu_valid = 1'b1; cpu_write = 1'b1; cpu_idx = 2'd1;
        tick();
        cpu_valid = 1'b0;
        check("t4_op_inv", bus_req_op, 2'b01);
        snoop_valid = 1'b1; snoop_op = 2'b01; snoop_idx = 2'd1;
        tick();
        snoop_valid = 1'b0;
        check("t4_line1_i", state_vec[3:2], 2'b00);
        check("t4_op_wm", bus_req_op, 2'b10);
        check("t4_valid_held", bus_req_valid, 1);
        check("t4_no_wb", wb_valid, 0);
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        check("t4_line1_e", state_vec[3:2], 2'b01);
        check("t4_done", cpu_done, 1);
        tick();

        // Line 0 exclusive, line 3 shared, then read hit with a snoop elsewhere.
        quick_miss(1'b1, 2'd0);
        quick_miss(1'b0, 2'd3);
        check("t5_pre_state", state_vec, 8'b10_00_01_01);
        cpu_valid = 1'b1; cpu_write = 1'b0; cpu_idx = 2'd3;
        snoop_valid = 1'b1; snoop_op = 2'b10; snoop_idx = 2'd0;
        tick();
        cpu_valid = 1'b0; snoop_valid = 1'b0;
        check("t5_hit_done", cpu_done, 1);
        check("t5_no_req", bus_req_valid, 0);
        check("t5_wb_valid", wb_valid, 1);
        check("t5_wb_idx", wb_idx, 0);
        check("t5_state", state_vec, 8'b10_00_01_00);
        tick();
        check("t5_ready_back", cpu_ready, 1);
        check("t5_done_pulse", cpu_done, 0);

        // Reset while a request is pending.
        cpu_valid = 1'b1; cpu_write = 1'b1; cpu_idx = 2'd2;
        tick();
        cpu_valid = 1'b0;
        check("t6_pending", bus_req_valid, 1);
        resetn = 1'b0;
        #1;
        check("t6_rst_valid", bus_req_valid, 0);
        check("t6_rst_state", state_vec, 0);
        tick();
        resetn = 1'b1;
        tick();
        check("t6_ready", cpu_ready, 1);
        check("t6_idle_valid", bus_req_valid, 0);
        check("t6_no_done", cpu_done, 0);

        // Op 11 snoop leaves an exclusive line alone.
        quick_miss(1'b1, 2'd2);
        check("t6_line2_e", state_vec, 8'b00_01_00_00);
        snoop_valid = 1'b1; snoop_op = 2'b11; snoop_idx = 2'd2;
        tick();
        snoop_valid = 1'b0;
        check("t6_op11_state", state_vec, 8'b00_01_00_00);
        check("t6_op11_wb", wb_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
